// File: rtl/tile_load_driver.sv
// ---------------------------------------------------------------------------
// tile_load_driver
//
// Upstream feeder for the convolution chip. One load_start runs NB_TILES
// tiles. For each tile the driver accepts MAIN_WORDS host (addr,data) words
// and replays them onto a_input/b_input with int_mem_we. It then accepts
// OVERLAP_WORDS more words and replays them with overlap_cache_we. After one
// flush cycle it pulses data_ready and waits for fsm_done before it starts
// the next tile.
//
// Optional feature (macro TILE_ADDR_CHECK_EN):
//   When defined, a word with an out-of-range address is consumed but not
//   written, and the sticky addr_err flag is set. When undefined, every
//   consumed word is written and addr_err is tied to 0.
//
// Ports
//   clk              clock
//   arst_n_in        asynchronous reset, active low
//   load_start       start a run of NB_TILES tiles (sampled in IDLE only)
//   in_addr/in_data  host word; in_valid/in_ready handshake
//   fsm_done         chip finished computing the current tile
//   a_input/b_input  registered write address/data to the chip
//   int_mem_we       write strobe, input/kernel memories
//   overlap_cache_we write strobe, overlap cache
//   data_ready       1-cycle pulse: tile fully written
//   tile_idx         tiles completed in the current run
//   busy             driver is not idle
//   addr_err         sticky out-of-range address flag
// ---------------------------------------------------------------------------
module tile_load_driver #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int MAIN_WORDS    = 16896,
  parameter int OVERLAP_WORDS = 256,
  parameter int NB_TILES      = 32
) (
  input  logic                         clk,
  input  logic                         arst_n_in,
  input  logic                         load_start,
  input  logic [IO_DATA_WIDTH-1:0]     in_addr,
  input  logic [IO_DATA_WIDTH-1:0]     in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         fsm_done,
  output logic [IO_DATA_WIDTH-1:0]     a_input,
  output logic [IO_DATA_WIDTH-1:0]     b_input,
  output logic                         int_mem_we,
  output logic                         overlap_cache_we,
  output logic                         data_ready,
  output logic [$clog2(NB_TILES+1)-1:0] tile_idx,
  output logic                         busy,
  output logic                         addr_err
);

  localparam int MAX_WORDS = (MAIN_WORDS > OVERLAP_WORDS) ? MAIN_WORDS : OVERLAP_WORDS;
  localparam int CW        = $clog2(MAX_WORDS + 1);
  localparam int TW        = $clog2(NB_TILES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MAIN,
    LOAD_OVL,
    FLUSH,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   word_cnt;
  logic            transfer;
  logic            last_main;
  logic            last_ovl;
  logic            last_tile;
  logic            addr_ok;

  // The handshake must be combinational so a word is taken in the same cycle
  // the host presents it.
  assign in_ready  = (state == LOAD_MAIN) || (state == LOAD_OVL);
  assign busy      = (state != IDLE);
  assign transfer  = in_ready && in_valid;
  assign last_main = (word_cnt == CW'(MAIN_WORDS - 1));
  assign last_ovl  = (word_cnt == CW'(OVERLAP_WORDS - 1));
  assign last_tile = ((tile_idx + TW'(1)) == TW'(NB_TILES));

  // Address legality of the word currently on the host bus.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    addr_ok = 1'b1;
`ifdef TILE_ADDR_CHECK_EN
    if (state == LOAD_OVL) begin
      addr_ok = (in_addr[15:8] == 8'h00);
    end else if (in_addr[15]) begin
      addr_ok = (in_addr[14:9] == 6'h00);    // kernel memory is 512 words
    end else begin
      addr_ok = !in_addr[14];                // input memory is 16K words
    end
`endif
  end

`ifndef TILE_ADDR_CHECK_EN
  assign addr_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the datapath registers (a_input/b_input) are reset too. Resetting
  // them keeps the outputs defined at 0 out of reset, and they are only
  // 2*IO_DATA_WIDTH flops, not a memory.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state            <= IDLE;
      word_cnt         <= '0;
      tile_idx         <= '0;
      a_input          <= '0;
      b_input          <= '0;
      int_mem_we       <= 1'b0;
      overlap_cache_we <= 1'b0;
      data_ready       <= 1'b0;
`ifdef TILE_ADDR_CHECK_EN
      addr_err         <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle: they are high only in the cycle after a transfer.
      int_mem_we       <= 1'b0;
      overlap_cache_we <= 1'b0;
      data_ready       <= 1'b0;

      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= LOAD_MAIN;
            tile_idx <= '0;
            word_cnt <= '0;
`ifdef TILE_ADDR_CHECK_EN
            addr_err <= 1'b0;
`endif
          end
        end

        LOAD_MAIN: begin
          if (transfer) begin
            if (addr_ok) begin
              a_input    <= in_addr;
              b_input    <= in_data;
              int_mem_we <= 1'b1;
            end
`ifdef TILE_ADDR_CHECK_EN
            else begin
              addr_err <= 1'b1;
            end
`endif
            if (last_main) begin
              word_cnt <= '0;
              state    <= (OVERLAP_WORDS == 0) ? FLUSH : LOAD_OVL;
            end else begin
              word_cnt <= word_cnt + CW'(1);
            end
          end
        end

        LOAD_OVL: begin
          if (transfer) begin
            if (addr_ok) begin
              a_input          <= in_addr;
              b_input          <= in_data;
              overlap_cache_we <= 1'b1;
            end
`ifdef TILE_ADDR_CHECK_EN
            else begin
              addr_err <= 1'b1;
            end
`endif
            if (last_ovl) begin
              word_cnt <= '0;
              state    <= FLUSH;
            end else begin
              word_cnt <= word_cnt + CW'(1);
            end
          end
        end

        // The last strobe is visible during FLUSH; data_ready follows it.
        FLUSH: begin
          data_ready <= 1'b1;
          state      <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (fsm_done) begin
            tile_idx <= tile_idx + TW'(1);
            word_cnt <= '0;
            state    <= last_tile ? IDLE : LOAD_MAIN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_load_driver.sv
// ---------------------------------------------------------------------------
// tb_tile_load_driver
//
// Two instances share the clock, reset and host stimulus. dut1 has an overlap
// phase (MAIN_WORDS=4, OVERLAP_WORDS=2, NB_TILES=2). dut0 has none
// (OVERLAP_WORDS=0). Each instance is compared every cycle against a
// reference model that counts words accepted per tile as a single total.
// The address-check expectations follow the TILE_ADDR_CHECK_EN macro.
// ---------------------------------------------------------------------------
module tb_tile_load_driver;

  localparam int M  = 4;
  localparam int O  = 2;
  localparam int NB = 2;
  localparam int TW = $clog2(NB + 1);

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        load_start;
  logic        fsm_done;
  logic        in_valid;
  logic [15:0] in_addr;
  logic [15:0] in_data;

  logic          d1_ready, d1_mwe, d1_owe, d1_dr, d1_busy, d1_err;
  logic [15:0]   d1_a, d1_b;
  logic [TW-1:0] d1_tile;
  logic          d0_ready, d0_mwe, d0_owe, d0_dr, d0_busy, d0_err;
  logic [15:0]   d0_a, d0_b;
  logic [TW-1:0] d0_tile;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tile_load_driver #(.IO_DATA_WIDTH(16), .MAIN_WORDS(M), .OVERLAP_WORDS(O), .NB_TILES(NB)) dut1 (
    .clk(clk), .arst_n_in(arst_n_in), .load_start(load_start),
    .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .in_ready(d1_ready),
    .fsm_done(fsm_done), .a_input(d1_a), .b_input(d1_b),
    .int_mem_we(d1_mwe), .overlap_cache_we(d1_owe), .data_ready(d1_dr),
    .tile_idx(d1_tile), .busy(d1_busy), .addr_err(d1_err)
  );

  tile_load_driver #(.IO_DATA_WIDTH(16), .MAIN_WORDS(M), .OVERLAP_WORDS(0), .NB_TILES(NB)) dut0 (
    .clk(clk), .arst_n_in(arst_n_in), .load_start(load_start),
    .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .in_ready(d0_ready),
    .fsm_done(fsm_done), .a_input(d0_a), .b_input(d0_b),
    .int_mem_we(d0_mwe), .overlap_cache_we(d0_owe), .data_ready(d0_dr),
    .tile_idx(d0_tile), .busy(d0_busy), .addr_err(d0_err)
  );

  // Reference model: words accepted in this tile (k) plus run/flush/wait flags.
  typedef struct {
    bit          loading;
    bit          flush;
    bit          waiting;
    bit          err;
    bit          we_m;
    bit          we_o;
    bit          dr;
    int          k;
    int          tiles;
    logic [15:0] a;
    logic [15:0] b;
  } mdl_t;

  mdl_t m1, m0;
  bit   accepted;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.loading = 0; r.flush = 0; r.waiting = 0; r.err = 0;
    r.we_m = 0; r.we_o = 0; r.dr = 0; r.k = 0; r.tiles = 0;
    r.a = '0; r.b = '0;
    return r;
  endfunction

  function automatic bit addr_ok(logic [15:0] ad, bit ovl);
`ifdef TILE_ADDR_CHECK_EN
    if (ovl) return (ad < 16'h0100);
    if (ad >= 16'h8000) return (ad < 16'h8200);
    return (ad < 16'h4000);
`else
    return (ad == ad) || ovl;
`endif
  endfunction

  function automatic mdl_t step(mdl_t m, int mw, int ow, bit ls, bit v,
                                logic [15:0] ad, logic [15:0] dt, bit done);
    mdl_t n = m;
    bit   ovl;
    n.we_m = 0; n.we_o = 0; n.dr = 0;
    if (m.loading) begin
      if (v) begin
        ovl = (m.k >= mw);
        if (addr_ok(ad, ovl)) begin
          n.we_m = !ovl; n.we_o = ovl; n.a = ad; n.b = dt;
        end else begin
          n.err = 1;
        end
        n.k = m.k + 1;
        if (n.k == mw + ow) begin
          n.loading = 0; n.flush = 1;
        end
      end
    end else if (m.flush) begin
      n.flush = 0; n.waiting = 1; n.dr = 1;
    end else if (m.waiting) begin
      if (done) begin
        n.tiles   = m.tiles + 1;
        n.waiting = 0;
        n.k       = 0;
        n.loading = (n.tiles < NB);
      end
    end else if (ls) begin
      n.loading = 1; n.k = 0; n.tiles = 0; n.err = 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input string n, input mdl_t m, input logic rdy, input logic bsy,
                           input logic mwe, input logic owe, input logic dr,
                           input logic [TW-1:0] ti, input logic err,
                           input logic [15:0] a, input logic [15:0] b);
    check({n, ".in_ready"}, 32'(rdy), 32'(m.loading));
    check({n, ".busy"}, 32'(bsy), 32'(m.loading || m.flush || m.waiting));
    check({n, ".int_mem_we"}, 32'(mwe), 32'(m.we_m));
    check({n, ".overlap_cache_we"}, 32'(owe), 32'(m.we_o));
    check({n, ".data_ready"}, 32'(dr), 32'(m.dr));
    check({n, ".tile_idx"}, 32'(ti), 32'(m.tiles));
    check({n, ".addr_err"}, 32'(err), 32'(m.err));
    if (m.we_m || m.we_o) begin
      check({n, ".a_input"}, 32'(a), 32'(m.a));
      check({n, ".b_input"}, 32'(b), 32'(m.b));
    end
  endtask

  task automatic check_all();
    check_dut("dut1", m1, d1_ready, d1_busy, d1_mwe, d1_owe, d1_dr, d1_tile, d1_err, d1_a, d1_b);
    check_dut("dut0", m0, d0_ready, d0_busy, d0_mwe, d0_owe, d0_dr, d0_tile, d0_err, d0_a, d0_b);
  endtask

  // One clock: update both models at the rising edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    accepted = m1.loading && in_valid;
    if (!arst_n_in) begin
      m1 = mdl_reset();
      m0 = mdl_reset();
    end else begin
      m1 = step(m1, M, O, load_start, in_valid, in_addr, in_data, fsm_done);
      m0 = step(m0, M, 0, load_start, in_valid, in_addr, in_data, fsm_done);
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [15:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case (r[31:29])
      3'd0:    return 16'h4000;
      3'd1:    return r[15:0];
      3'd2:    return {2'b00, r[13:0]};
      3'd3:    return {7'b1000000, r[8:0]};
      default: return {8'h00, r[7:0]};
    endcase
  endfunction

  // Host driver: holds an unaccepted word, otherwise presents a new one.
  task automatic drive(input int pv, input int pd, input int pls);
    if (!(in_valid && !accepted)) begin
      in_valid = ($urandom_range(99) < pv);
      in_addr  = rand_addr();
      in_data  = 16'($urandom);
    end
    fsm_done   = ($urandom_range(99) < pd);
    load_start = ($urandom_range(99) < pls);
  endtask

  initial begin
    arst_n_in  = 1'b0;
    load_start = 1'b0;
    fsm_done   = 1'b0;
    in_valid   = 1'b0;
    in_addr    = '0;
    in_data    = '0;
    accepted   = 1'b0;
    m1 = mdl_reset();
    m0 = mdl_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check_all();
    arst_n_in = 1'b1;

    // Host always valid: full tiles back to back, spurious done/start mixed in.
    for (int i = 0; i < 200; i++) begin
      drive(100, 15, 30);
      tick();
    end

    // Asynchronous reset in the middle of LOAD_MAIN.
    load_start = 1'b1;
    in_valid   = 1'b1;
    fsm_done   = 1'b1;
    begin
      int guard = 0;
      while (!(m1.loading && m1.k >= 2 && m1.k < M) && guard < 40) begin
        tick();
        guard++;
      end
      check("reset_setup_reached", 32'(m1.loading && m1.k >= 2 && m1.k < M), 32'd1);
    end
    #2 arst_n_in = 1'b0;
    #1;
    m1 = mdl_reset();
    m0 = mdl_reset();
    check_all();
    load_start = 1'b0;
    tick();
    arst_n_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      fsm_done = 1'b0;
      tick();
    end

    // Randomized backpressure, done and start.
    for (int i = 0; i < 2500; i++) begin
      drive(50, 20, 25);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
